// File: rtl/mem_bank_pkg.sv
// Shared constants and address-decode helpers for the banked memory array.
// Holds the stall-injection LFSR constants used when MEM_STALL_INJECT_EN is defined.
package mem_bank_pkg;

    localparam int MAX_RD_LATENCY = 4;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [31:0] addr_field(input logic [63:0] addr, input int lsb,
                                               input int width);
        logic [63:0] mask;
        mask = (width == 0) ? 64'd0 : ((64'd1 << width) - 64'd1);
        return 32'((addr >> lsb) & mask);
    endfunction

    function automatic logic [31:0] bank_of(input logic [63:0] addr, input int off_bits,
                                            input int bank_bits);
        return addr_field(addr, off_bits, bank_bits);
    endfunction

    function automatic logic [31:0] row_of(input logic [63:0] addr, input int off_bits,
                                           input int bank_bits, input int row_bits);
        return addr_field(addr, off_bits + bank_bits, row_bits);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    endfunction

endpackage

// File: rtl/mem_bank_rr_arb.sv
// Round-robin arbiter for one bank: the port after the last winner has top priority.
// A high stall input suppresses every grant and freezes the pointer for that cycle.
module mem_bank_rr_arb #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 stall,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_next;
    logic          hit;
    int            idx;

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value held over from the previous evaluation and no latch is inferred.
    always_comb begin
        gnt      = '0;
        hit      = 1'b0;
        idx      = 0;
        ptr_next = ptr_q;
        if (!stall) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = (int'(ptr_q) + i) % NUM_PORTS;
                if (!hit && req[idx]) begin
                    gnt[idx] = 1'b1;
                    hit      = 1'b1;
                    ptr_next = PW'((idx + 1) % NUM_PORTS);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_next;
    end

endmodule

// File: rtl/mem_bank_array.sv
// Word-interleaved multi-port memory: per-bank round-robin arbitration, fixed-latency responses.
// Optional stall injection per bank is enabled with the MEM_STALL_INJECT_EN macro.
module mem_bank_array
    import mem_bank_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_WORDS = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_PORTS-1:0]                    req_i,
    output logic [NUM_PORTS-1:0]                    gnt_o,
    input  logic [NUM_PORTS-1:0]                    we_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
    output logic [NUM_PORTS-1:0]                    rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int BANK_LOG = $clog2(NUM_BANKS);
    localparam int ROW_LOG  = $clog2(BANK_WORDS);
    localparam int BW       = (NUM_BANKS > 1) ? BANK_LOG : 1;
    localparam int RW       = (BANK_WORDS > 1) ? ROW_LOG : 1;
    localparam int LAT      = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                              (RD_LATENCY < 1) ? 1 : RD_LATENCY;

    logic [BW-1:0]          bank_sel   [NUM_PORTS];
    logic [RW-1:0]          row_sel    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   bank_req   [NUM_BANKS];
    logic [NUM_PORTS-1:0]   bank_gnt   [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  bank_rdata [NUM_BANKS];
    logic [NUM_PORTS-1:0]   accept;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_sel[p] = BW'(bank_of(64'(addr_i[p]), OFF_BITS, BANK_LOG));
            row_sel[p]  = RW'(row_of(64'(addr_i[p]), OFF_BITS, BANK_LOG, ROW_LOG));
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++)
            for (int p = 0; p < NUM_PORTS; p++)
                bank_req[b][p] = req_i[p] && (int'(bank_sel[p]) == b);
    end

    // A port only ever requests one bank, so OR-ing across banks yields its grant.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            gnt_o = gnt_o | bank_gnt[b];
    end

    assign accept = req_i & gnt_o;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  stall;
        logic                  acc;
        logic                  wr;
        logic [RW-1:0]         row;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BYTES-1:0]      be;
        logic [DATA_WIDTH-1:0] rdata_q;
        logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

`ifdef MEM_STALL_INJECT_EN
        logic [15:0] lfsr_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lfsr_q <= LFSR_SEED ^ 16'(b);
            else        lfsr_q <= lfsr_next(lfsr_q);
        end
        assign stall = lfsr_q[0];
`else
        assign stall = 1'b0;
`endif

        mem_bank_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (bank_req[b]),
            .stall (stall),
            .gnt   (bank_gnt[b])
        );

        always_comb begin
            acc   = |bank_gnt[b];
            wr    = 1'b0;
            row   = '0;
            wdata = '0;
            be    = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    wr    = we_i[p];
                    row   = row_sel[p];
                    wdata = wdata_i[p];
                    be    = be_i[p];
                end
            end
        end

        // NOTE: the storage array has no reset; clearing it would defeat RAM inference,
        // and every response path is qualified by reset-cleared valid flags instead.
        always_ff @(posedge clk) begin
            if (acc && wr) begin
                for (int i = 0; i < BYTES; i++)
                    if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
            end
            if (acc && !wr) rdata_q <= mem[row];
        end

        assign bank_rdata[b] = rdata_q;
    end

    // First response stage: remembers which bank to pick the read word from.
    logic [NUM_PORTS-1:0]                 acc_q;
    logic [NUM_PORTS-1:0]                 rd_q;
    logic [BW-1:0]                        bank_q [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] resp0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rd_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) bank_q[p] <= '0;
        end else begin
            acc_q <= accept;
            rd_q  <= ~we_i;
            for (int p = 0; p < NUM_PORTS; p++) bank_q[p] <= bank_sel[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            resp0_data[p] = (acc_q[p] && rd_q[p]) ? bank_rdata[bank_q[p]] : '0;
    end

    if (LAT == 1) begin : g_lat1
        assign rvalid_o = acc_q;
        assign rdata_o  = resp0_data;
    end else begin : g_pipe
        logic [NUM_PORTS-1:0]                 v_q [LAT-1];
        logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] d_q [LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LAT - 1; k++) begin
                    v_q[k] <= '0;
                    d_q[k] <= '0;
                end
            end else begin
                v_q[0] <= acc_q;
                d_q[0] <= resp0_data;
                for (int k = 1; k < LAT - 1; k++) begin
                    v_q[k] <= v_q[k-1];
                    d_q[k] <= d_q[k-1];
                end
            end
        end

        assign rvalid_o = v_q[LAT-2];
        assign rdata_o  = d_q[LAT-2];
    end

endmodule
